// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Wide enough for read latencies 1..7.
    localparam int LAT_CNT_BITS = 3;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the memory-side port of the arbiter.
interface dmem_arbiter_if #(
    parameter int DBITS = 32,
    parameter int ABITS = 32
);
    logic             req0;
    logic             we0;
    logic [ABITS-1:0] addr0;
    logic [DBITS-1:0] wdata0;
    logic             ack0;
    logic [DBITS-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic [ABITS-1:0] addr1;
    logic [DBITS-1:0] wdata1;
    logic             ack1;
    logic [DBITS-1:0] rdata1;

    logic             mem_we;
    logic [ABITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;
    logic             busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the port not served last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = PORT_CPU;
        if (req0 && req1) begin
            grant_idx = ~last_served;
        end else if (req1) begin
            grant_idx = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one transaction at a time, registered read data.
// Optional grant counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DBITS        = 32,
    parameter int ABITS        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]    grant_cnt0,
    output logic [15:0]    grant_cnt1
`endif
);

    localparam logic [LAT_CNT_BITS-1:0] LAT_INIT = LAT_CNT_BITS'(READ_LATENCY);
    localparam logic [LAT_CNT_BITS-1:0] LAT_ONE  = LAT_CNT_BITS'(1);

    state_t                  state_reg, state_next;
    logic                    last_served_reg;
    logic                    gidx_reg;
    logic                    we_reg;
    logic [ABITS-1:0]        addr_reg;
    logic [DBITS-1:0]        wdata_reg;
    logic [LAT_CNT_BITS-1:0] cnt_reg;
    logic [DBITS-1:0]        rdata0_reg, rdata1_reg;
    logic                    grant_valid, grant_idx;
    logic                    grant_fire;

    rr_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_served (last_served_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign grant_fire = (state_reg == IDLE) && grant_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = we_reg ? DONE : WAIT;
            WAIT:    if (cnt_reg == LAT_ONE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from state so reset kills them without waiting for a clock.
    always_comb begin
        bus.mem_we = (state_reg == ISSUE) && we_reg;
        bus.ack0   = (state_reg == DONE) && (gidx_reg == PORT_CPU);
        bus.ack1   = (state_reg == DONE) && (gidx_reg == PORT_DBG);
        bus.busy   = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_served_reg <= PORT_DBG;
            gidx_reg        <= PORT_CPU;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            cnt_reg         <= '0;
            rdata0_reg      <= '0;
            rdata1_reg      <= '0;
        end else begin
            if (grant_fire) begin
                gidx_reg        <= grant_idx;
                last_served_reg <= grant_idx;
                we_reg          <= grant_idx ? bus.we1    : bus.we0;
                addr_reg        <= grant_idx ? bus.addr1  : bus.addr0;
                wdata_reg       <= grant_idx ? bus.wdata1 : bus.wdata0;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= LAT_INIT;
            end
            if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - LAT_ONE;
                // Only the granted port's read register ever changes.
                if (cnt_reg == LAT_ONE) begin
                    if (gidx_reg == PORT_DBG) begin
                        rdata1_reg <= bus.mem_rdata;
                    end else begin
                        rdata0_reg <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.rdata0    = rdata0_reg;
    assign bus.rdata1    = rdata1_reg;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] grant_cnt0_reg, grant_cnt1_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt0_reg <= '0;
            grant_cnt1_reg <= '0;
        end else if (grant_fire) begin
            if (grant_idx == PORT_DBG) begin
                grant_cnt1_reg <= sat_inc16(grant_cnt1_reg);
            end else begin
                grant_cnt0_reg <= sat_inc16(grant_cnt0_reg);
            end
        end
    end

    assign grant_cnt0 = grant_cnt0_reg;
    assign grant_cnt1 = grant_cnt1_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: READ_LATENCY=1 main instance plus a READ_LATENCY=3 instance.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_rd0, exp_rd1;
    logic [31:0] mem [0:255];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    dmem_arbiter_if #(.DBITS(32), .ABITS(32)) bus ();
    dmem_arbiter_if #(.DBITS(32), .ABITS(32)) bus3 ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gc0, gc1, gc0_3, gc1_3;
`endif

    dmem_arbiter #(.DBITS(32), .ABITS(32), .READ_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    dmem_arbiter #(.DBITS(32), .ABITS(32), .READ_LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
`ifdef DMEM_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0_3),
        .grant_cnt1 (gc1_3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory shared by both instances; only the main instance writes it.
    always @(posedge clk) begin
        if (!reset) begin
            mem[65] <= 32'h12345678;
            mem[66] <= 32'hCAFEF00D;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        pipe1    <= mem[bus.mem_addr[9:2]];
        pipe3[0] <= mem[bus3.mem_addr[9:2]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign bus.mem_rdata  = pipe1;
    assign bus3.mem_rdata = pipe3[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops one expectation and checks port, timing and both read registers.
    always @(negedge clk) begin
        if (!reset) begin
            exp_rd0 = 32'h0;
            exp_rd1 = 32'h0;
        end
        if (bus.ack0 && bus.ack1) begin
            chk("dual_ack", 1, 0);
        end else if (bus.ack0 || bus.ack1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {63'h0, bus.ack1}, 64'hFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.rd) begin
                    if (e.port == 0) exp_rd0 = e.data;
                    else             exp_rd1 = e.data;
                end
                chk("ack_port", {63'h0, bus.ack1}, e.port);
                if (e.cyc != 0) chk("ack_cycle", cyc, e.cyc);
                chk("rdata0", bus.rdata0, exp_rd0);
                chk("rdata1", bus.rdata1, exp_rd1);
                $display("[TB] ack port %0d cycle %0d rdata0=%h rdata1=%h", e.port, cyc, bus.rdata0, bus.rdata1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic txn(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit got;
        got = 1'b0;
        if (p == 0) begin
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
        end else begin
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? bus.ack0 : bus.ack1) got = 1'b1;
        end
        chk($sformatf("ack_seen_p%0d", p), {63'h0, got}, 1);
        @(posedge clk);
        #1;
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tests = 0; fails = 0; cyc = 0;
        reset = 1'b0;
        {bus.req0, bus.we0, bus.req1, bus.we1} = '0;
        bus.addr0 = '0; bus.wdata0 = '0; bus.addr1 = '0; bus.wdata1 = '0;
        {bus3.req0, bus3.we0, bus3.req1, bus3.we1} = '0;
        bus3.addr0 = '0; bus3.wdata0 = '0; bus3.addr1 = '0; bus3.wdata1 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_busy_rl3", bus3.busy, 0);
        @(posedge clk); #1 reset = 1'b1;
        idle(1);

        // Single write from port 0
        n = cyc;
        sbq.push_back('{port: 0, rd: 1'b0, data: 32'h0, cyc: n + 2});
        fork
            txn(0, 1'b1, 32'h100, 32'hDEADBEEF);
            begin
                @(negedge clk); chk("wr_we_n", bus.mem_we, 0);
                @(negedge clk);
                chk("wr_we_n1", bus.mem_we, 1);
                chk("wr_addr_n1", bus.mem_addr, 32'h100);
                chk("wr_wdata_n1", bus.mem_wdata, 32'hDEADBEEF);
                @(negedge clk); chk("wr_we_n2", bus.mem_we, 0);
            end
        join
        idle(1);

        // Single read from port 1
        n = cyc;
        sbq.push_back('{port: 1, rd: 1'b1, data: 32'h12345678, cyc: n + 3});
        fork
            txn(1, 1'b0, 32'h104, 32'h0);
            begin
                bit saw;
                saw = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (bus.mem_we) saw = 1'b1;
                end
                chk("rd_no_we", {63'h0, saw}, 0);
            end
        join
        idle(1);

        // Read back the earlier write through port 0
        n = cyc;
        sbq.push_back('{port: 0, rd: 1'b1, data: 32'hDEADBEEF, cyc: n + 3});
        txn(0, 1'b0, 32'h100, 32'h0);
        idle(1);

        // Both held high: port 0 was served last, so order is 1,0,1,0
        n = cyc;
        sbq.push_back('{port: 1, rd: 1'b1, data: 32'hCAFEF00D, cyc: n + 3});
        sbq.push_back('{port: 0, rd: 1'b1, data: 32'h12345678, cyc: n + 7});
        sbq.push_back('{port: 1, rd: 1'b1, data: 32'hCAFEF00D, cyc: n + 11});
        sbq.push_back('{port: 0, rd: 1'b1, data: 32'h12345678, cyc: n + 15});
        bus.we0 = 1'b0; bus.addr0 = 32'h104;
        bus.we1 = 1'b0; bus.addr1 = 32'h108;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        idle(16);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        idle(2);
        chk("alt_drained", sbq.size(), 0);

        // Reset during WAIT aborts the read with no ack
        bus.we1 = 1'b0; bus.addr1 = 32'h100; bus.req1 = 1'b1;
        idle(2);
        reset = 1'b0;
        bus.req1 = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_mem_we", bus.mem_we, 0);
        chk("abort_ack1", bus.ack1, 0);
        idle(2);
        reset = 1'b1;
        idle(3);
        chk("abort_idle_busy", bus.busy, 0);

        // First tie after reset goes to port 0
        n = cyc;
        sbq.push_back('{port: 0, rd: 1'b0, data: 32'h0, cyc: n + 2});
        sbq.push_back('{port: 1, rd: 1'b0, data: 32'h0, cyc: n + 5});
        fork
            txn(0, 1'b1, 32'h10C, 32'h000000AA);
            txn(1, 1'b1, 32'h110, 32'h000000BB);
        join
        idle(1);

        // READ_LATENCY=3 instance: read acks at N+5 even though req0 drops at N+2
        n = cyc;
        bus3.we0 = 1'b0; bus3.addr0 = 32'h108; bus3.req0 = 1'b1;
        idle(2);
        bus3.req0 = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("rl3_ack0_n%0d", c), bus3.ack0, (c == 5));
            chk($sformatf("rl3_ack1_n%0d", c), bus3.ack1, 0);
            if (c == 5) chk("rl3_rdata0", bus3.rdata0, 32'hCAFEF00D);
        end
        chk("rl3_start", cyc, n + 6);
        idle(1);

`ifdef DMEM_ARB_STATS_EN
        // Grant counters: 5 + 2 grants from reset, then saturation
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{port: 0, rd: 1'b0, data: 32'h0, cyc: cyc + 2});
            txn(0, 1'b1, 32'h120, i);
            idle(1);
        end
        for (int i = 0; i < 2; i++) begin
            sbq.push_back('{port: 1, rd: 1'b0, data: 32'h0, cyc: cyc + 2});
            txn(1, 1'b1, 32'h124, i);
            idle(1);
        end
        chk("stats_cnt0", gc0, 16'd5);
        chk("stats_cnt1", gc1, 16'd2);
        force dut.grant_cnt0_reg = 16'hFFFF;
        idle(1);
        release dut.grant_cnt0_reg;
        sbq.push_back('{port: 0, rd: 1'b0, data: 32'h0, cyc: cyc + 2});
        txn(0, 1'b1, 32'h128, 32'h1);
        idle(1);
        chk("stats_sat0", gc0, 16'hFFFF);
        chk("stats_hold1", gc1, 16'd2);
`endif

        chk("sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/memory-mapped-I/O port between two requesters: port 0 is the CPU load/store path and port 1 is the debug/DMA loader.
- Each requester uses a req/ack handshake. The arbiter issues one transaction at a time to the data memory and returns read data registered.
- Sits between the CPU datapath (ALU result as address, register read port 2 as write data) and the data memory block.

Parameters:
- DBITS, 32, data width.
- ABITS, 32, address width.
- READ_LATENCY, 1, cycles from address presented to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high with we0/addr0/wdata0 stable until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  ABITS  port 0 address.
- wdata0  in  DBITS  port 0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- rdata0  out  DBITS  port 0 read data; valid with ack0 and held until the next port 0 read completes.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ABITS  memory address.
- mem_wdata  out  DBITS  memory write data.
- mem_rdata  in  DBITS  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-low): state = IDLE; last_served = 1, so port 0 wins the first tie. All outputs are 0: ack0/1, rdata0/1, mem_we, mem_addr, mem_wdata, busy.
- Reset asserted mid-transaction aborts immediately; mem_we drops asynchronously.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick a port and latch its we/addr/wdata plus the granted index; go to ISSUE.
  - Pick rule: only one req high → that port. Both high → the port that is not last_served.
  - Update last_served at grant.
- ISSUE (1 cycle):
  - mem_addr/mem_wdata driven from the latched values; mem_we = latched we.
  - Write → DONE. Read → WAIT with counter = READ_LATENCY.
- WAIT:
  - mem_addr is held and mem_we = 0. Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture mem_rdata into the granted port's rdata register; go to DONE.
- DONE (1 cycle): ack of the granted port = 1; go to IDLE.
- Outside ISSUE/WAIT: mem_we = 0; mem_addr/mem_wdata hold their last values.
- Latency, with req sampled high in IDLE at cycle N:
  - Write: mem_we at N+1, ack at N+2.
  - Read: ack at N+2+READ_LATENCY, which is N+3 for the default.
- Throughput: one transaction per 3 (write) or 3+READ_LATENCY (read) cycles. With both requesters continuously asserting, grants alternate strictly.
- req dropped before ack is a protocol violation. The latched transaction still completes and ack still pulses.
- A requester must drop req in the cycle following ack (the IDLE cycle); otherwise it is treated as a new request.
- The rdata of the non-granted port is never disturbed.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1, each 16 bits. Each increments on its port's grant, saturates at 16'hFFFF, and resets to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (dmem_arb_pkg):
  - state enum {IDLE, ISSUE, WAIT, DONE}.
  - Port index constants PORT_CPU = 0, PORT_DBG = 1.
  - Latency-counter width constant (3).
- One sub-module, rr_pick2: combinational 2-way round-robin selector. Inputs req0, req1, last_served; outputs grant_valid, grant_idx.

Test Plan:
- Reset then single write: req0 = 1, we0 = 1, addr0 = 0x100, wdata0 = 0xDEADBEEF at cycle N → mem_we = 1 with mem_addr = 0x100 and mem_wdata = 0xDEADBEEF at N+1; ack0 at N+2; ack1 never asserted.
- Single read, READ_LATENCY = 1: req1 read of addr 0x104, memory returns 0x12345678 one cycle after the address → ack1 and rdata1 = 0x12345678 at N+3; rdata0 unchanged; mem_we = 0 throughout.
- Simultaneous requests after reset: req0 and req1 both high → port 0 granted first. Port 1 is granted in the IDLE cycle after ack0. Keeping both asserted produces grant order 0, 1, 0, 1.
- Reset mid-read: assert reset in WAIT → in the same cycle, busy = 0, mem_we = 0, and no ack is issued. After release, last_served = 1 and the next tie goes to port 0.
- READ_LATENCY = 3 build: a port 0 read acks at N+5 with the data presented 3 cycles after ISSUE. Verify that req0 dropped at N+2 still yields ack0.
- With DMEM_ARB_STATS_EN defined: 5 port 0 grants and 2 port 1 grants → grant_cnt0 = 5, grant_cnt1 = 2. Force grant_cnt0 to 16'hFFFF and grant once more → it stays 16'hFFFF.
